// File: rtl/exec_pkg.sv
// Shared types, ALU opcodes, flag indices and instruction decode for the exec_ctrl slice.
// Define EXEC_IMM_EN to decode the ADDI/SUBI/CMPI immediate forms.
package exec_pkg;

  localparam int REG_W  = 16;
  localparam int ADDR_W = 4;
  localparam int FLAG_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK
  } state_t;

  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_AND  = 8'h01;
  localparam logic [7:0] ALU_OR   = 8'h02;
  localparam logic [7:0] ALU_XOR  = 8'h03;
  localparam logic [7:0] ALU_NOT  = 8'h04;
  localparam logic [7:0] ALU_ADD  = 8'h05;
  localparam logic [7:0] ALU_ADDU = 8'h06;
  localparam logic [7:0] ALU_ADDC = 8'h07;
  localparam logic [7:0] ALU_MUL  = 8'h08;
  localparam logic [7:0] ALU_SUB  = 8'h09;
  localparam logic [7:0] ALU_CMP  = 8'h0B;
  localparam logic [7:0] ALU_CMPU = 8'h0F;
  localparam logic [7:0] ALU_LSHI = 8'h80;
  localparam logic [7:0] ALU_LSH  = 8'h84;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  typedef struct packed {
    logic [7:0] op;
    logic       wr;
    logic       flag_upd;
    logic       use_imm;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] ins);
    dec_t d;
    d.op       = {ins[15:12], ins[7:4]};
    d.wr       = 1'b0;
    d.flag_upd = 1'b0;
    d.use_imm  = 1'b0;
    case (ins[15:12])
      4'h0: begin
        if (d.op >= ALU_AND && d.op <= ALU_SUB) begin
          d.wr       = 1'b1;
          d.flag_upd = 1'b1;
        end else if (d.op == ALU_CMP || d.op == ALU_CMPU) begin
          d.flag_upd = 1'b1;
        end
      end
      4'h8: begin
        d.wr       = 1'b1;
        d.flag_upd = 1'b1;
      end
`ifdef EXEC_IMM_EN
      4'h5: begin
        d.op       = ALU_ADD;
        d.wr       = 1'b1;
        d.flag_upd = 1'b1;
        d.use_imm  = 1'b1;
      end
      4'h9: begin
        d.op       = ALU_SUB;
        d.wr       = 1'b1;
        d.flag_upd = 1'b1;
        d.use_imm  = 1'b1;
      end
      4'hB: begin
        d.op       = ALU_CMP;
        d.flag_upd = 1'b1;
        d.use_imm  = 1'b1;
      end
`endif
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// General register file: two operand read ports, one debug read port, one write port.
// Every register clears asynchronously while rst_n is low.
module exec_regfile
  import exec_pkg::*;
#(
  parameter int REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [REG_W-1:0]  ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [REG_W-1:0]  rb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [REG_W-1:0]  dbg_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [REG_W-1:0]  wd
);

  logic [REG_W-1:0] regs_reg [REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we) begin
      regs_reg[wa] <= wd;
    end
  end

  // Reads are combinational so a write only shows up the cycle after it is clocked.
  assign ra_data  = regs_reg[ra_addr];
  assign rb_data  = regs_reg[rb_addr];
  assign dbg_data = regs_reg[dbg_addr];

endmodule

// File: rtl/exec_ctrl.sv
// Four-state instruction sequencer driving an external ALU and the register file.
// Define EXEC_IMM_EN (seen by exec_pkg) to enable the sign-extended immediate forms.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [REG_W-1:0]  alu_a,
  output logic [REG_W-1:0]  alu_b,
  output logic [7:0]        alu_op,
  input  logic [REG_W-1:0]  alu_c,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [FLAG_W-1:0] psr,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [REG_W-1:0]  dbg_data
);

  state_t            state_reg, state_next;
  logic [15:0]       instr_reg;
  logic [REG_W-1:0]  alu_a_reg, alu_b_reg, res_reg;
  logic [7:0]        alu_op_reg;
  logic [FLAG_W-1:0] flags_reg, psr_reg;
  logic              wr_reg, flag_upd_reg, done_reg;
  logic [REG_W-1:0]  rd_a, rd_b, imm_ext;
  logic              wb_we;
  dec_t              dec_now;

  assign dec_now = decode(instr_reg);
  assign imm_ext = {{8{instr_reg[7]}}, instr_reg[7:0]};
  assign wb_we   = (state_reg == ST_WRITEBACK) && wr_reg;

  exec_regfile #(.REGS(REGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (instr_reg[11:8]),
    .ra_data  (rd_a),
    .rb_addr  (instr_reg[3:0]),
    .rb_data  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_we),
    .wa       (instr_reg[11:8]),
    .wd       (res_reg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Gated by rst_n so the block never advertises readiness while held in reset.
        instr_ready = rst_n;
        if (instr_valid) begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE:    state_next = ST_EXECUTE;
      ST_EXECUTE:   state_next = ST_WRITEBACK;
      ST_WRITEBACK: state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg    <= '0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_op_reg   <= ALU_NOP;
      res_reg      <= '0;
      flags_reg    <= '0;
      psr_reg      <= '0;
      wr_reg       <= 1'b0;
      flag_upd_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_reg <= instr;
          end
        end
        ST_DECODE: begin
          // Both operands are captured here, so Rdest == Rsrc sees pre-write values.
          alu_a_reg    <= rd_a;
          alu_b_reg    <= dec_now.use_imm ? imm_ext : rd_b;
          alu_op_reg   <= dec_now.op;
          wr_reg       <= dec_now.wr;
          flag_upd_reg <= dec_now.flag_upd;
        end
        ST_EXECUTE: begin
          res_reg   <= alu_c;
          flags_reg <= alu_flags;
        end
        ST_WRITEBACK: begin
          if (flag_upd_reg) begin
            psr_reg <= flags_reg;
          end
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_a  = alu_a_reg;
  assign alu_b  = alu_b_reg;
  assign alu_op = alu_op_reg;
  assign psr    = psr_reg;
  assign done   = done_reg;

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter REGS, default 16, meaning number of 16-bit general registers; addresses are 4 bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr  input  16  instruction: [15:12] op hi, [11:8] Rdest, [7:4] op ext / imm hi, [3:0] Rsrc / imm lo.
REQ-005 SHALL have port instr_valid  input  1  instr is valid.
REQ-006 SHALL have port instr_ready  output  1  block accepts instr this cycle.
REQ-007 SHALL have port alu_a, alu_b  output  16 each  operands driven to the downstream ALU.
REQ-008 SHALL have port alu_op  output  8  opcode driven to the ALU.
REQ-009 SHALL have port alu_c  input  16  ALU result.
REQ-010 SHALL have port alu_flags  input  5  ALU flags, ZCFNL (4 zero, 3 carry, 2 overflow, 1 negative, 0 low).
REQ-011 SHALL have port psr  output  5  registered flags from the last flag-updating instruction.
REQ-012 SHALL have port done  output  1  one-cycle pulse when an instruction retires.
REQ-013 SHALL have port dbg_addr  input  4  debug register select.
REQ-014 SHALL have port dbg_data  output  16  combinational read of register dbg_addr.

Function
REQ-015 SHALL implement FSM IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE, one cycle per state, 4 cycles per instruction.
REQ-016 SHALL assert instr_ready only in IDLE; capture instr on clk when instr_valid && instr_ready; stay in IDLE otherwise.
REQ-017 SHALL, in DECODE, register alu_a = R[Rdest], alu_op = {op hi, op ext}, alu_b = R[Rsrc] (register forms) or the immediate (REQ-029).
REQ-018 SHALL hold alu_a/alu_b/alu_op stable through EXECUTE and WRITEBACK, and sample alu_c/alu_flags at the end of EXECUTE.
REQ-019 SHALL, in WRITEBACK, write R[Rdest] = sampled alu_c for op hi 0000 with ext 0001..1001, and op hi 1000 (shifts).
REQ-020 SHALL NOT write R[Rdest] for CMP (0x0B) or CMPU (0x0F); psr still updates.
REQ-021 SHALL update psr = sampled alu_flags in WRITEBACK for every op in REQ-019/020; psr unchanged otherwise.
REQ-022 SHALL treat alu_op 0x00 (NOP/WAIT), ext 1010/1100-1110, and any unlisted op hi as NOP: no register write, psr unchanged, done still pulses.
REQ-023 SHALL pulse done for exactly one cycle, the cycle after WRITEBACK, coincident with return to IDLE.
REQ-024 SHALL make a write visible on dbg_data the cycle after WRITEBACK; dbg_data shows the old value during WRITEBACK.
REQ-025 SHALL handle Rdest == Rsrc by reading both operands before the write.
REQ-026 SHALL accept back-to-back instructions with instr_valid held high: the next instr is accepted in the IDLE cycle where done pulses.

Reset
REQ-027 SHALL, while rst_n = 0: state IDLE, all registers 0, psr 0, alu_a/alu_b/alu_op 0, done 0, instr_ready 0; after release instr_ready = 1 in IDLE.
REQ-028 SHALL, on reset mid-instruction, abandon it with no register write, no psr update and no done.

Configuration
REQ-029 SHALL, when EXEC_IMM_EN is defined, decode op hi 0101 (ADDI), 1001 (SUBI), 1011 (CMPI) with alu_b = sign-extended instr[7:0] and alu_op 0x05, 0x09, 0x0B; ADDI/SUBI write Rdest, CMPI updates psr only.
REQ-030 SHALL, when EXEC_IMM_EN is undefined, treat op hi 0101/1001/1011 as NOP per REQ-022.

Structure
REQ-031 SHALL put the FSM state enum, alu_op constants (AND 0x01 .. CMPU 0x0F, LSHI 0x80, LSH 0x84) and flag bit indices in a shared package exec_pkg.
REQ-032 SHALL put the register array in sub-module exec_regfile: 2 combinational read ports, 1 debug read port, 1 synchronous write port, asynchronous active-low clear.

Verification
REQ-033 SHALL check: reset, then dbg_addr 0..15 -> all 0x0000, psr 00000, instr_ready 1.
REQ-034 SHALL check: R1=0x7FFF, R2=0x0001, instr 0x0152 (ADD R1,R2), ALU model -> done 4 cycles after acceptance, R1=0x8000, psr 00100.
REQ-035 SHALL check: R3=0x0005, R4=0x0009, CMP 0x03B4 -> R3 still 0x0005, psr = model flags, no write.
REQ-036 SHALL check: with EXEC_IMM_EN, R5=0x0010, instr 0x95FF (SUBI R5,-1) -> R5=0x0011; without it -> R5 unchanged, psr unchanged, done pulses.
REQ-037 SHALL check: rst_n low during EXECUTE of ADD -> no write, no done, state IDLE after release.
REQ-038 SHALL check: three back-to-back instructions with instr_valid held high -> retire 4 cycles apart, results in order.
